// File: rtl/branch_redirect_arbiter.sv
// Arbitrates exception, second-amend and first-amend flushes into one BPU
// checkpoint-restore burst followed by a fetch redirect handshake.
module branch_redirect_arbiter #(
    parameter int unsigned VADDR_W       = 32,
    parameter int unsigned CKPT_W        = 8,
    parameter int unsigned REPAIR_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,

    input  logic               exc_req_i,
    input  logic [VADDR_W-1:0] exc_dest_i,

    input  logic               sba_req_i,
    input  logic [VADDR_W-1:0] sba_dest_i,
    input  logic               sba_take_i,
    input  logic [CKPT_W-1:0]  sba_ckpt_i,
    input  logic [VADDR_W-1:0] sba_errPC_i,

    input  logic               fba_req_i,
    input  logic [VADDR_W-1:0] fba_dest_i,
    input  logic               fba_take_i,
    input  logic [CKPT_W-1:0]  fba_ckpt_i,
    input  logic [VADDR_W-1:0] fba_errPC_i,

    output logic               sba_ack_o,
    output logic               fba_ack_o,

    output logic               rep_valid_o,
    output logic [CKPT_W-1:0]  rep_ckpt_o,
    output logic               rep_take_o,
    output logic [VADDR_W-1:0] rep_errPC_o,

    output logic               redir_valid_o,
    output logic [VADDR_W-1:0] redir_dest_o,
    input  logic               redir_ready_i,

    output logic               busy_o,
    output logic [31:0]        mispredict_cnt_o
);

    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {IDLE, REPAIR, REDIRECT} state_t;
    typedef enum logic [1:0] {SRC_NONE, SRC_EXC, SRC_SBA, SRC_FBA} src_t;

    state_t            state;
    src_t              src;
    logic [CNT_W-1:0]  repair_cnt;
    logic              sba_accept;
    logic              fba_accept;

    // The older instruction wins; an exc flush blocks both branch acks.
    assign sba_accept = !rst && sba_req_i && !exc_req_i &&
                        ((state == IDLE) || (src == SRC_FBA));
    assign fba_accept = !rst && fba_req_i && !exc_req_i && !sba_req_i &&
                        (state == IDLE);

    // Acks are same-cycle accept pulses, so they decode the live request.
    assign sba_ack_o = sba_accept;
    assign fba_ack_o = fba_accept;

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            src              <= SRC_NONE;
            repair_cnt       <= '0;
            mispredict_cnt_o <= '0;
            rep_valid_o      <= 1'b0;
            rep_ckpt_o       <= '0;
            rep_take_o       <= 1'b0;
            rep_errPC_o      <= '0;
            redir_valid_o    <= 1'b0;
            redir_dest_o     <= '0;
            busy_o           <= 1'b0;
        end else if (exc_req_i) begin
            // Exception preempts everything, including a handshake this cycle.
            state         <= REDIRECT;
            src           <= SRC_EXC;
            redir_dest_o  <= exc_dest_i;
            repair_cnt    <= '0;
            rep_valid_o   <= 1'b0;
            redir_valid_o <= 1'b1;
            busy_o        <= 1'b1;
        end else if (sba_accept || fba_accept) begin
            state            <= REPAIR;
            src              <= sba_accept ? SRC_SBA : SRC_FBA;
            redir_dest_o     <= sba_accept ? sba_dest_i  : fba_dest_i;
            rep_take_o       <= sba_accept ? sba_take_i  : fba_take_i;
            rep_ckpt_o       <= sba_accept ? sba_ckpt_i  : fba_ckpt_i;
            rep_errPC_o      <= sba_accept ? sba_errPC_i : fba_errPC_i;
            mispredict_cnt_o <= mispredict_cnt_o + 32'd1;
            repair_cnt       <= CNT_W'(REPAIR_CYCLES - 1);
            rep_valid_o      <= 1'b1;
            redir_valid_o    <= 1'b0;
            busy_o           <= 1'b1;
        end else begin
            case (state)
                REPAIR: begin
                    if (repair_cnt == '0) begin
                        state         <= REDIRECT;
                        rep_valid_o   <= 1'b0;
                        redir_valid_o <= 1'b1;
                    end else begin
                        repair_cnt <= repair_cnt - CNT_W'(1);
                    end
                end
                REDIRECT: begin
                    if (redir_ready_i) begin
                        state         <= IDLE;
                        src           <= SRC_NONE;
                        redir_valid_o <= 1'b0;
                        busy_o        <= 1'b0;
                    end
                end
                default: begin
                    state         <= IDLE;
                    rep_valid_o   <= 1'b0;
                    redir_valid_o <= 1'b0;
                    busy_o        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_branch_redirect_arbiter.sv
// Scoreboard bench for branch_redirect_arbiter: directed flush scenarios push
// expected acks, repair bursts and redirects; a negedge monitor checks them.
module tb_branch_redirect_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        exc_req_i;
    logic [31:0] exc_dest_i;
    logic        sba_req_i, sba_take_i;
    logic [31:0] sba_dest_i, sba_errPC_i;
    logic [7:0]  sba_ckpt_i;
    logic        fba_req_i, fba_take_i;
    logic [31:0] fba_dest_i, fba_errPC_i;
    logic [7:0]  fba_ckpt_i;
    logic        sba_ack_o, fba_ack_o;
    logic        rep_valid_o, rep_take_o;
    logic [7:0]  rep_ckpt_o;
    logic [31:0] rep_errPC_o;
    logic        redir_valid_o, redir_ready_i;
    logic [31:0] redir_dest_o;
    logic        busy_o;
    logic [31:0] mispredict_cnt_o;

    branch_redirect_arbiter #(.VADDR_W(32), .CKPT_W(8), .REPAIR_CYCLES(2)) dut (
        .clk(clk), .rst(rst),
        .exc_req_i(exc_req_i), .exc_dest_i(exc_dest_i),
        .sba_req_i(sba_req_i), .sba_dest_i(sba_dest_i), .sba_take_i(sba_take_i),
        .sba_ckpt_i(sba_ckpt_i), .sba_errPC_i(sba_errPC_i),
        .fba_req_i(fba_req_i), .fba_dest_i(fba_dest_i), .fba_take_i(fba_take_i),
        .fba_ckpt_i(fba_ckpt_i), .fba_errPC_i(fba_errPC_i),
        .sba_ack_o(sba_ack_o), .fba_ack_o(fba_ack_o),
        .rep_valid_o(rep_valid_o), .rep_ckpt_o(rep_ckpt_o), .rep_take_o(rep_take_o),
        .rep_errPC_o(rep_errPC_o),
        .redir_valid_o(redir_valid_o), .redir_dest_o(redir_dest_o),
        .redir_ready_i(redir_ready_i),
        .busy_o(busy_o), .mispredict_cnt_o(mispredict_cnt_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic sba; logic fba; int cyc; } ack_t;
    typedef struct { int start; int len; logic [7:0] ckpt; logic take; logic [31:0] errpc; } rep_t;
    typedef struct { int cyc; logic [31:0] dest; logic [31:0] cnt; } redir_t;

    ack_t   ack_q[$];
    rep_t   rep_q[$];
    redir_t redir_q[$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs();
        exc_req_i = 0; sba_req_i = 0; fba_req_i = 0;
    endtask

    task automatic push_ack(input logic s, input logic f, input int c);
        ack_t a; a.sba = s; a.fba = f; a.cyc = c; ack_q.push_back(a);
    endtask

    task automatic push_rep(input int st, input int ln, input logic [7:0] ck,
                            input logic tk, input logic [31:0] ep);
        rep_t r; r.start = st; r.len = ln; r.ckpt = ck; r.take = tk; r.errpc = ep;
        rep_q.push_back(r);
    endtask

    task automatic push_redir(input int c, input logic [31:0] d, input logic [31:0] n);
        redir_t r; r.cyc = c; r.dest = d; r.cnt = n; redir_q.push_back(r);
    endtask

    task automatic drive_sba(input logic [31:0] d, input logic [7:0] ck, input logic tk,
                             input logic [31:0] ep);
        sba_req_i = 1; sba_dest_i = d; sba_ckpt_i = ck; sba_take_i = tk; sba_errPC_i = ep;
    endtask

    task automatic drive_fba(input logic [31:0] d, input logic [7:0] ck, input logic tk,
                             input logic [31:0] ep);
        fba_req_i = 1; fba_dest_i = d; fba_ckpt_i = ck; fba_take_i = tk; fba_errPC_i = ep;
    endtask

    // Monitor state
    int          rep_len = 0;
    int          rep_start = 0;
    logic [7:0]  rep_ck_seen;
    logic        rep_tk_seen;
    logic [31:0] rep_ep_seen;
    logic        prev_valid = 0, prev_hs = 0, prev_exc = 0;
    logic [31:0] prev_dest = '0;

    always @(negedge clk) begin
        logic hs;
        ack_t a;
        rep_t r;
        redir_t d;
        hs = redir_valid_o && redir_ready_i && !exc_req_i && !rst;

        if (sba_ack_o || fba_ack_o) begin
            if (ack_q.size() == 0) begin
                chk("ack_unexpected", {62'd0, sba_ack_o, fba_ack_o}, 64'd0);
            end else begin
                a = ack_q.pop_front();
                chk("ack_sel", {62'd0, sba_ack_o, fba_ack_o}, {62'd0, a.sba, a.fba});
                chk("ack_cyc", 64'(cyc), 64'(a.cyc));
            end
        end

        if (rep_valid_o || redir_valid_o)
            chk("rep_redir_excl", {63'd0, rep_valid_o & redir_valid_o}, 64'd0);

        if (redir_valid_o && prev_valid && !prev_hs && !prev_exc)
            chk("redir_stable", 64'(redir_dest_o), 64'(prev_dest));

        if (rep_valid_o) begin
            if (rep_len == 0) rep_start = cyc;
            rep_len++;
            rep_ck_seen = rep_ckpt_o;
            rep_tk_seen = rep_take_o;
            rep_ep_seen = rep_errPC_o;
        end else if (rep_len > 0) begin
            if (rep_q.size() == 0) begin
                chk("rep_unexpected", 64'(rep_len), 64'd0);
            end else begin
                r = rep_q.pop_front();
                chk("rep_start", 64'(rep_start), 64'(r.start));
                chk("rep_len", 64'(rep_len), 64'(r.len));
                chk("rep_ckpt", 64'(rep_ck_seen), 64'(r.ckpt));
                chk("rep_take", {63'd0, rep_tk_seen}, {63'd0, r.take});
                chk("rep_errpc", 64'(rep_ep_seen), 64'(r.errpc));
            end
            rep_len = 0;
        end

        if (hs) begin
            if (redir_q.size() == 0) begin
                chk("redir_unexpected", 64'(redir_dest_o), 64'd0);
            end else begin
                d = redir_q.pop_front();
                chk("redir_cyc", 64'(cyc), 64'(d.cyc));
                chk("redir_dest", 64'(redir_dest_o), 64'(d.dest));
                chk("redir_cnt", 64'(mispredict_cnt_o), 64'(d.cnt));
            end
        end

        prev_valid = redir_valid_o;
        prev_hs    = hs;
        prev_exc   = exc_req_i;
        prev_dest  = redir_dest_o;
    end

    int t0;

    initial begin
        rst = 1; clear_reqs(); redir_ready_i = 1;
        exc_dest_i = '0;
        sba_dest_i = '0; sba_ckpt_i = '0; sba_take_i = 0; sba_errPC_i = '0;
        fba_dest_i = '0; fba_ckpt_i = '0; fba_take_i = 0; fba_errPC_i = '0;
        tick(); tick();
        chk("rst_busy", {63'd0, busy_o}, 64'd0);
        chk("rst_rep_valid", {63'd0, rep_valid_o}, 64'd0);
        chk("rst_redir_valid", {63'd0, redir_valid_o}, 64'd0);
        chk("rst_cnt", 64'(mispredict_cnt_o), 64'd0);
        rst = 0;

        // Single fba repair and redirect
        tick(); t0 = cyc;
        drive_fba(32'h8000_1000, 8'h5A, 1'b1, 32'h8000_0FFC);
        push_ack(0, 1, t0);
        push_rep(t0 + 1, 2, 8'h5A, 1'b1, 32'h8000_0FFC);
        push_redir(t0 + 3, 32'h8000_1000, 32'd1);
        tick(); clear_reqs();
        tick(); tick(); tick();
        chk("t1_idle_busy", {63'd0, busy_o}, 64'd0);

        // Same-cycle exc, sba, fba: exc wins, no repair, no count
        tick(); t0 = cyc;
        exc_req_i = 1; exc_dest_i = 32'hBFC0_0380;
        drive_sba(32'h8000_AAAA, 8'hAA, 1'b1, 32'h8000_AAA0);
        drive_fba(32'h8000_BBBB, 8'hBB, 1'b0, 32'h8000_BBB0);
        push_redir(t0 + 1, 32'hBFC0_0380, 32'd1);
        tick(); clear_reqs();
        tick(); tick();

        // sba preempts fba in first repair cycle
        tick(); t0 = cyc;
        drive_fba(32'h8000_1111, 8'h11, 1'b1, 32'h8000_1110);
        push_ack(0, 1, t0);
        tick(); clear_reqs();
        drive_sba(32'h8000_2000, 8'h22, 1'b0, 32'h8000_1FF8);
        push_ack(1, 0, t0 + 1);
        push_rep(t0 + 1, 3, 8'h22, 1'b0, 32'h8000_1FF8);
        push_redir(t0 + 4, 32'h8000_2000, 32'd3);
        tick(); clear_reqs();
        tick(); tick(); tick(); tick();

        // Stalled redirect, ignored requests while busy, exc replaces dest
        redir_ready_i = 0;
        tick(); t0 = cyc;
        drive_sba(32'h8000_3000, 8'h33, 1'b1, 32'h8000_2FFC);
        push_ack(1, 0, t0);
        push_rep(t0 + 1, 2, 8'h33, 1'b1, 32'h8000_2FFC);
        push_redir(t0 + 8, 32'hBFC0_0200, 32'd4);
        tick(); clear_reqs();
        drive_fba(32'h8000_CCCC, 8'hCC, 1'b0, 32'h8000_CCC0);
        tick(); clear_reqs();
        drive_sba(32'h8000_DDDD, 8'hDD, 1'b0, 32'h8000_DDD0);
        tick(); clear_reqs();
        tick();
        chk("t4_stall_dest", 64'(redir_dest_o), 64'h8000_3000);
        tick();
        exc_req_i = 1; exc_dest_i = 32'hBFC0_0200;
        tick(); clear_reqs();
        tick();
        chk("t4_exc_dest", 64'(redir_dest_o), 64'hBFC0_0200);
        chk("t4_valid_held", {63'd0, redir_valid_o}, 64'd1);
        tick(); redir_ready_i = 1;
        tick(); tick();

        // Reset mid-repair, then a fresh sba
        tick(); t0 = cyc;
        drive_fba(32'h8000_4000, 8'h44, 1'b0, 32'h8000_3FF0);
        push_ack(0, 1, t0);
        push_rep(t0 + 1, 1, 8'h44, 1'b0, 32'h8000_3FF0);
        tick(); clear_reqs();
        rst = 1;
        drive_sba(32'h8000_EEEE, 8'hEE, 1'b1, 32'h8000_EEE0);
        tick(); clear_reqs(); rst = 0;
        chk("t5_rep_valid", {63'd0, rep_valid_o}, 64'd0);
        chk("t5_redir_valid", {63'd0, redir_valid_o}, 64'd0);
        chk("t5_busy", {63'd0, busy_o}, 64'd0);
        chk("t5_cnt", 64'(mispredict_cnt_o), 64'd0);
        chk("t5_ckpt", 64'(rep_ckpt_o), 64'd0);
        chk("t5_errpc", 64'(rep_errPC_o), 64'd0);
        chk("t5_dest", 64'(redir_dest_o), 64'd0);
        tick();
        drive_sba(32'h8000_5000, 8'h55, 1'b1, 32'h8000_4FFC);
        push_ack(1, 0, t0 + 3);
        push_rep(t0 + 4, 2, 8'h55, 1'b1, 32'h8000_4FFC);
        push_redir(t0 + 6, 32'h8000_5000, 32'd1);
        tick(); clear_reqs();
        tick(); tick(); tick(); tick();

        // sba and fba together: only sba acked
        tick(); t0 = cyc;
        drive_sba(32'h8000_6000, 8'h66, 1'b0, 32'h8000_5FF0);
        drive_fba(32'h8000_7000, 8'h77, 1'b1, 32'h8000_6FF0);
        push_ack(1, 0, t0);
        push_rep(t0 + 1, 2, 8'h66, 1'b0, 32'h8000_5FF0);
        push_redir(t0 + 3, 32'h8000_6000, 32'd2);
        tick(); clear_reqs();
        tick(); tick(); tick();

        // exc during repair cuts the burst short
        tick(); t0 = cyc;
        drive_fba(32'h8000_8000, 8'h88, 1'b1, 32'h8000_7FF0);
        push_ack(0, 1, t0);
        push_rep(t0 + 1, 1, 8'h88, 1'b1, 32'h8000_7FF0);
        push_redir(t0 + 2, 32'hBFC0_0400, 32'd3);
        tick(); clear_reqs();
        exc_req_i = 1; exc_dest_i = 32'hBFC0_0400;
        tick(); clear_reqs();
        tick(); tick();

        // exc supersedes a handshake in the same cycle
        tick(); t0 = cyc;
        drive_sba(32'h8000_9000, 8'h99, 1'b0, 32'h8000_8FF0);
        push_ack(1, 0, t0);
        push_rep(t0 + 1, 2, 8'h99, 1'b0, 32'h8000_8FF0);
        push_redir(t0 + 4, 32'hBFC0_0500, 32'd4);
        tick(); clear_reqs();
        tick(); tick();
        exc_req_i = 1; exc_dest_i = 32'hBFC0_0500;
        tick(); clear_reqs();
        tick(); tick(); tick();

        chk("ack_q_drained", 64'(ack_q.size()), 64'd0);
        chk("rep_q_drained", 64'(rep_q.size()), 64'd0);
        chk("redir_q_drained", 64'(redir_q.size()), 64'd0);
        chk("final_idle", {63'd0, busy_o}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_redirect_arbiter.md
BRANCH_REDIRECT_ARBITER -- requirements
Module: branch_redirect_arbiter

Interface
REQ-001 SHALL have parameter VADDR_W, default 32, virtual-address width.
REQ-002 SHALL have parameter CKPT_W, default 8, checkpoint-info width.
REQ-003 SHALL have parameter REPAIR_CYCLES, default 2, checkpoint-restore duration in cycles (legal range 1..15).
REQ-004 SHALL use one clock and a synchronous, active-high reset; ports: clk in 1, rising-edge clock; rst in 1, synchronous active-high reset.
REQ-005 SHALL have ports exc_req_i in 1 (CP0 exception flush) and exc_dest_i in VADDR_W (handler address).
REQ-006 SHALL have ports sba_req_i in 1 (second-amend flush, PREMEM), sba_dest_i in VADDR_W, sba_take_i in 1, sba_ckpt_i in CKPT_W, sba_errPC_i in VADDR_W.
REQ-007 SHALL have ports fba_req_i in 1 (first-amend flush, EXE), fba_dest_i in VADDR_W, fba_take_i in 1, fba_ckpt_i in CKPT_W, fba_errPC_i in VADDR_W.
REQ-008 SHALL have outputs sba_ack_o out 1 and fba_ack_o out 1, each a one-cycle accept pulse.
REQ-009 SHALL have outputs rep_valid_o out 1, rep_ckpt_o out CKPT_W, rep_take_o out 1 and rep_errPC_o out VADDR_W, forming the BPU checkpoint-restore bus.
REQ-010 SHALL have outputs redir_valid_o out 1 and redir_dest_o out VADDR_W, plus input redir_ready_i in 1, forming the fetch redirect handshake.
REQ-011 SHALL have outputs busy_o out 1 (pipeline freeze) and mispredict_cnt_o out 32 (accepted branch repairs).

Function
REQ-012 SHALL implement FSM states IDLE, REPAIR and REDIRECT; busy_o = (state != IDLE).
REQ-013 SHALL use fixed priority exc > sba > fba; the older instruction wins.
REQ-014 In IDLE, exc_req_i SHALL latch exc_dest_i and go to REDIRECT next cycle; no repair is performed.
REQ-015 In IDLE without exc, sba_req_i (else fba_req_i) SHALL latch dest/take/ckpt/errPC, pulse the matching ack the same cycle, increment mispredict_cnt_o by 1, load the repair counter to REPAIR_CYCLES-1 and go to REPAIR.
REQ-016 In REPAIR: rep_valid_o=1 with latched ckpt/take/errPC; counter decrements each cycle; at 0 the FSM SHALL go to REDIRECT, so rep_valid_o is high for exactly REPAIR_CYCLES cycles.
REQ-017 In REDIRECT: redir_valid_o=1 and redir_dest_o SHALL hold the latched value stable until redir_valid_o && redir_ready_i; then go to IDLE.
REQ-018 exc_req_i in REPAIR or REDIRECT SHALL preempt: overwrite dest, drop rep_valid_o next cycle, enter or stay in REDIRECT; a pending handshake in the same cycle SHALL be superseded, so redir_valid_o stays 1 with the exc dest.
REQ-019 sba_req_i while serving an fba request (REPAIR or REDIRECT) SHALL preempt it: re-latch, ack, count, restart REPAIR from REPAIR_CYCLES-1.
REQ-020 fba_req_i while busy SHALL be ignored (no ack); sba_req_i while serving sba or exc SHALL be ignored.
REQ-021 Simultaneous requests in one cycle SHALL resolve by REQ-013; only the winner is acked and counted.
REQ-022 mispredict_cnt_o SHALL wrap modulo 2^32; the exc path SHALL never increment it.
REQ-023 redir_valid_o SHALL never be 1 in the same cycle as rep_valid_o.

Reset
REQ-024 rst=1 at a clock edge SHALL force state IDLE and clear the repair counter, mispredict_cnt_o, all latched fields, all acks, rep_valid_o, redir_valid_o and busy_o to 0, aborting any operation in flight.
REQ-025 During rst, requests SHALL be ignored; the first accept can occur in the first cycle after rst deasserts.

Verification
REQ-026 fba_req_i=1, dest=0x80001000, REPAIR_CYCLES=2, redir_ready_i=1 -> fba_ack_o in cycle 0, rep_valid_o in cycles 1-2, redir_valid_o=1 with dest 0x80001000 in cycle 3, IDLE in cycle 4, cnt=1.
REQ-027 Same-cycle exc (0xBFC00380), sba and fba -> no acks, no rep_valid_o, redir_dest_o=0xBFC00380, cnt unchanged.
REQ-028 fba accepted, sba_req_i (dest 0x80002000) arrives in the first REPAIR cycle -> sba_ack_o pulses, REPAIR restarts for 2 cycles, redirect carries 0x80002000, cnt=2.
REQ-029 REDIRECT with redir_ready_i=0 for 5 cycles -> redir_valid_o and dest stable for 5 cycles; exc arriving in cycle 3 replaces dest; handshake completes with the exc dest.
REQ-030 rst asserted mid-REPAIR -> next cycle all outputs 0, cnt=0; a fresh sba request after reset completes normally.
